// File: rtl/plic_gateway.sv
// plic_gateway: interrupt gateway in front of a PLIC.
// Turns raw level/edge interrupt lines into at most one outstanding request
// per source, holds it until claimed, and masks the source until completed.
// Edge sources keep a saturating count of edges that have not been forwarded.
// Optional macro PLIC_GATEWAY_SYNC_EN inserts a 2-flop synchronizer on each
// raw line for asynchronous peripherals (adds 2 cycles of latency).

module plic_gateway #(
    parameter int NUM_SRC = 7,
    parameter int IDW     = 3,
    parameter int CNT_W   = 3
) (
    input  logic               plic_clock_i,
    input  logic               plic_reset_i,
    input  logic [NUM_SRC-1:0] irq_raw_i,
    input  logic [NUM_SRC-1:0] edge_mode_i,
    input  logic               claim_valid_i,
    input  logic [IDW-1:0]     claim_id_i,
    input  logic               complete_valid_i,
    input  logic [IDW-1:0]     complete_id_i,
    output logic [NUM_SRC-1:0] int_o,
    output logic [NUM_SRC-1:0] busy_o,
    output logic [NUM_SRC-1:0] overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_INFL = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_SRC-1:0] s;
    logic [NUM_SRC-1:0] s_prev_q, s_prev_d;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] claim_hit;
    logic [NUM_SRC-1:0] complete_hit;
    logic [NUM_SRC-1:0] consume;

    state_e             state_q [NUM_SRC];
    state_e             state_d [NUM_SRC];
    logic [CNT_W-1:0]   cnt_q   [NUM_SRC];
    logic [CNT_W-1:0]   cnt_d   [NUM_SRC];
    logic [NUM_SRC-1:0] ovf_q, ovf_d;
    logic [NUM_SRC-1:0] int_q, int_d;
    logic [NUM_SRC-1:0] busy_q, busy_d;

`ifdef PLIC_GATEWAY_SYNC_EN
    logic [NUM_SRC-1:0] sync1_q, sync1_d;
    logic [NUM_SRC-1:0] sync2_q, sync2_d;

    // Two-stage shift of the raw lines toward the clock domain.
    always_comb begin
        sync1_d = irq_raw_i;
        sync2_d = sync1_q;
    end

    // Synchronizer flops, cleared on reset so no stale edge survives it.
    always_ff @(posedge plic_clock_i) begin
        if (plic_reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign s = sync2_q;
`else
    assign s = irq_raw_i;
`endif

    assign rise = s & ~s_prev_q;

    // Decode the claim/complete strobes into one hit bit per source; IDs 0
    // and above NUM_SRC match no source and are therefore ignored.
    always_comb begin
        claim_hit    = '0;
        complete_hit = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            claim_hit[n]    = claim_valid_i    && (claim_id_i    == IDW'(n + 1));
            complete_hit[n] = complete_valid_i && (complete_id_i == IDW'(n + 1));
        end
    end

    // Per-source request FSM, pending-edge counter and sticky overflow.
    always_comb begin
        s_prev_d = s;
        consume  = '0;
        ovf_d    = ovf_q;
        int_d    = '0;
        busy_d   = '0;
        for (int n = 0; n < NUM_SRC; n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];

            case (state_q[n])
                ST_IDLE: begin
                    if (edge_mode_i[n]) begin
                        if ((cnt_q[n] != '0) || rise[n]) begin
                            state_d[n] = ST_PEND;
                            consume[n] = 1'b1;
                        end
                    end else if (s[n]) begin
                        state_d[n] = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (claim_hit[n]) begin
                        state_d[n] = ST_INFL;
                    end
                end
                ST_INFL: begin
                    if (complete_hit[n]) begin
                        state_d[n] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[n] = ST_IDLE;
                end
            endcase

            // A new edge on the consume cycle is the unit being forwarded, so
            // the count only drops when the request came from stored edges.
            if (!edge_mode_i[n]) begin
                cnt_d[n] = '0;
            end else if (consume[n]) begin
                if (!rise[n]) begin
                    cnt_d[n] = cnt_q[n] - CNT_W'(1);
                end
            end else if (rise[n]) begin
                if (cnt_q[n] == CNT_MAX) begin
                    ovf_d[n] = 1'b1;
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                end
            end

            int_d[n]  = (state_d[n] == ST_PEND);
            busy_d[n] = (state_d[n] == ST_INFL);
        end
    end

    // State, counters and registered outputs; reset wins over all strobes.
    always_ff @(posedge plic_clock_i) begin
        if (plic_reset_i) begin
            for (int n = 0; n < NUM_SRC; n++) begin
                state_q[n] <= ST_IDLE;
                cnt_q[n]   <= '0;
            end
            s_prev_q <= '0;
            ovf_q    <= '0;
            int_q    <= '0;
            busy_q   <= '0;
        end else begin
            for (int n = 0; n < NUM_SRC; n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
            s_prev_q <= s_prev_d;
            ovf_q    <= ovf_d;
            int_q    <= int_d;
            busy_q   <= busy_d;
        end
    end

    assign int_o      = int_q;
    assign busy_o     = busy_q;
    assign overflow_o = ovf_q;

endmodule

// File: doc/plic_gateway.md
Name: plic_gateway

Overview:
- Interrupt gateway in front of the 7-source PLIC; drives its `int_i` bus.
- Converts raw peripheral interrupt lines (level or edge, per source) into at most one outstanding request per source.
- Holds each source's request until the PLIC claims it, then masks the source until the matching complete.
- Edge sources keep a saturating count of edges not yet forwarded, so back-to-back edges are not lost.

Parameters:
- NUM_SRC, 7, number of interrupt sources; source ID n (1..NUM_SRC) maps to bit n-1.
- IDW, 3, claim/complete ID width; must satisfy 2^IDW > NUM_SRC.
- CNT_W, 3, width of the per-source pending-edge counter; saturates at 2^CNT_W-1.

Ports:
- plic_clock_i  in  1  clock.
- plic_reset_i  in  1  synchronous, active-high reset.
- irq_raw_i  in  NUM_SRC  raw peripheral interrupt lines.
- edge_mode_i  in  NUM_SRC  per source: 1 = rising-edge triggered, 0 = level triggered; quasi-static.
- claim_valid_i  in  1  PLIC claim strobe, one cycle per claim.
- claim_id_i  in  IDW  ID being claimed; 0 means no source.
- complete_valid_i  in  1  PLIC complete strobe.
- complete_id_i  in  IDW  ID being completed.
- int_o  out  NUM_SRC  registered request per source, to PLIC `int_i`.
- busy_o  out  NUM_SRC  1 while the source is claimed and awaiting complete.
- overflow_o  out  NUM_SRC  sticky: an edge was dropped because the counter was saturated.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, sampled on `plic_clock_i`.
- On reset:
  - all sources go to IDLE;
  - counters, edge-detect history and synchronizer flops clear to 0;
  - `int_o`, `busy_o` and `overflow_o` are all 0.
- Reset overrides every other input in the same cycle, including a reset asserted mid-claim: that source returns to IDLE and any later complete for it is ignored.
- Sampled input `s[n]`: `irq_raw_i` after the optional synchronizer.
- Edge event: `e[n] = s[n] & ~s_q[n]`, where `s_q` is `s` registered one cycle.
- Per-source FSM, with `int_o = (state == PEND)` and `busy_o = (state == INFL)`, both registered:
  - IDLE -> PEND when the request is live:
    - level mode: `s[n]`;
    - edge mode: `cnt[n] != 0 | e[n]`.
    - Entering PEND in edge mode consumes one unit: `cnt` next = `cnt + e - 1`, or `cnt` unchanged if it is fed only by the new edge.
  - PEND -> INFL on `claim_valid_i` with `claim_id_i == n+1`.
    - Level mode stays in PEND even if `s[n]` falls before the claim.
  - INFL -> IDLE on `complete_valid_i` with `complete_id_i == n+1`.
    - A new request is evaluated in IDLE on the next cycle, so `int_o` re-asserts 2 cycles after the complete strobe at the earliest.
  - Ignored strobes (no state change):
    - claim to a source in IDLE or INFL;
    - complete to a source in IDLE or PEND;
    - ID 0 or ID > NUM_SRC.
  - Claim and complete in the same cycle for different IDs are both applied. For the same ID, each acts only on the state it matches.
- Edge counter:
  - increments on `e[n]` in any state, except on the IDLE->PEND consume cycle;
  - saturates at 2^CNT_W-1; an edge arriving at saturation sets `overflow_o[n]`, which clears only on reset;
  - held at 0 while `edge_mode_i[n] == 0`.
- Mode change: changing `edge_mode_i[n]` outside IDLE has no effect on the current request.
- Latency: raw rise to `int_o` rise is 1 cycle without the synchronizer, 3 cycles with it.

Optional Feature:
- Macro: `PLIC_GATEWAY_SYNC_EN`.
- Defined: each `irq_raw_i` bit passes through a 2-flop synchronizer (reset to 0) before edge detect and FSM; all latencies add 2 cycles; suitable for asynchronous peripheral lines.
- Undefined: `irq_raw_i` is used directly and must already be synchronous to `plic_clock_i`.

Test Plan (no synchronizer unless stated):
- Level request: source 3 level, raise `irq_raw_i[2]` at cycle 0 → `int_o[2]` = 1 at cycle 1. Claim ID 3 at cycle 4 → `int_o[2]` = 0 and `busy_o[2]` = 1 at cycle 5. Complete ID 3 at cycle 6 with line still high → `busy_o[2]` = 0 at cycle 7, `int_o[2]` = 1 at cycle 8.
- Edge counting: source 1 edge, three rising edges while IDLE/PEND → three full claim/complete cycles produce three `int_o[0]` pulses, then `int_o[0]` stays 0 with `cnt` = 0.
- Counter saturation: CNT_W = 3, 9 edges on source 5 while INFL → `cnt` = 7, `overflow_o[4]` = 1 and stays set until reset; after complete, 7 further requests are delivered.
- Strobes that must be ignored:
  - claim ID 0 or ID 2 while source 2 is IDLE → no state change;
  - complete ID 4 while source 4 is PEND → `int_o[3]` stays 1.
- Simultaneous events:
  - claim ID 1 and complete ID 6 in the same cycle → both applied;
  - `plic_reset_i` = 1 while source 6 is INFL → all outputs 0 next cycle; a later complete ID 6 is ignored.
- `PLIC_GATEWAY_SYNC_EN` defined: level rise on source 7 at cycle 0 → `int_o[6]` = 1 at cycle 3.
